// File: rtl/perf_pkg.sv
// Shared types for the perf event dump path: FSM state encoding, counter type
// and ID width helper.
package perf_pkg;

  typedef enum logic {IDLE, SEND} perf_dump_state_t;

  localparam int EVENT_NUM_DEF = 8;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int PERF_ID_W     = $clog2(EVENT_NUM_DEF);

  typedef logic [CNT_WIDTH_DEF-1:0] perf_cnt_t;

  // Keeps the id port at least one bit wide for any legal event count.
  function automatic int perf_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One wrapping event counter; clear wins over a same-cycle increment.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/perf_event_dump.sv
// Per-event performance counters with an atomic snapshot streamed out one
// counter per beat over a valid/ready port.
//
//   state | meaning
//   IDLE  | counting only; dump_req takes a snapshot and starts a dump
//   SEND  | presenting snap[idx]; advance on handshake, leave after last beat
module perf_event_dump
  import perf_pkg::*;
#(
  parameter int EVENT_NUM     = 8,
  parameter int CNT_WIDTH     = 32,
  parameter bit CLEAR_ON_DUMP = 1'b0,
  localparam int ID_W         = perf_id_w(EVENT_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVENT_NUM-1:0] event_i,
  input  logic                 clear_i,
  input  logic                 dump_req,
  output logic                 dump_busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_id,
  output logic [CNT_WIDTH-1:0] out_cnt,
  output logic                 out_last
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(EVENT_NUM - 1);

  perf_dump_state_t     state_q, state_d;
  logic [ID_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt  [EVENT_NUM];
  logic [CNT_WIDTH-1:0] snap [EVENT_NUM];
  logic                 send, accept, last, hs, clr_all;

  assign send    = (state_q == SEND);
  assign accept  = (state_q == IDLE) && dump_req;
  assign last    = send && (idx_q == LAST_ID);
  assign hs      = send && out_ready;
  // Same-cycle events are lost when the dump also clears the live counters.
  assign clr_all = clear_i || (CLEAR_ON_DUMP && accept);

  for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cnt
    perf_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (event_i[g]),
      .clr (clr_all),
      .cnt (cnt[g])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ID_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot captures pre-increment values and stays frozen for the whole dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < EVENT_NUM; i++) snap[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < EVENT_NUM; i++) snap[i] <= cnt[i];
    end
  end

  assign dump_busy = send;
  assign out_valid = send;
  assign out_id    = send ? idx_q : '0;
  assign out_cnt   = send ? snap[idx_q] : '0;
  assign out_last  = last;

endmodule

// File: tb/tb_perf_event_dump.sv
// Scoreboard bench: stimulus pushes hand-computed beats, per-DUT monitors pop
// and compare whenever a beat is handshaken.
module tb_perf_event_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A: 8 events, 32-bit counters, snapshot keeps live counts
  logic [7:0]  a_ev;
  logic        a_clr, a_req, a_ready;
  logic        a_busy, a_valid, a_last;
  logic [2:0]  a_id;
  logic [31:0] a_cnt;

  // DUT B: 2 events, 4-bit counters, dump clears live counts
  logic [1:0]  b_ev;
  logic        b_clr, b_req, b_ready;
  logic        b_busy, b_valid, b_last;
  logic [0:0]  b_id;
  logic [3:0]  b_cnt;

  perf_event_dump #(.EVENT_NUM(8), .CNT_WIDTH(32), .CLEAR_ON_DUMP(1'b0)) u_a (
    .clk(clk), .rst(rst), .event_i(a_ev), .clear_i(a_clr), .dump_req(a_req),
    .dump_busy(a_busy), .out_valid(a_valid), .out_ready(a_ready),
    .out_id(a_id), .out_cnt(a_cnt), .out_last(a_last)
  );

  perf_event_dump #(.EVENT_NUM(2), .CNT_WIDTH(4), .CLEAR_ON_DUMP(1'b1)) u_b (
    .clk(clk), .rst(rst), .event_i(b_ev), .clear_i(b_clr), .dump_req(b_req),
    .dump_busy(b_busy), .out_valid(b_valid), .out_ready(b_ready),
    .out_id(b_id), .out_cnt(b_cnt), .out_last(b_last)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    int unsigned id;
    logic [31:0] cnt;
    bit          last;
  } beat_t;

  beat_t       qa[$];
  beat_t       qb[$];
  beat_t       ea, eb;
  logic [31:0] exp_a [8];
  logic [3:0]  exp_b [2];

  // Monitor A: ordered beat compare plus stall-stability checks
  bit          a_stall = 1'b0;
  logic [2:0]  a_sid;
  logic [31:0] a_scnt;

  always @(negedge clk) begin
    if (!rst) begin
      a_stall = 1'b0;
    end else if (a_valid) begin
      if (a_stall) begin
        chk("a_stall_id", a_id, a_sid);
        chk("a_stall_cnt", a_cnt, a_scnt);
      end
      if (a_ready) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_extra_beat actual_id=%0d required=no beat", a_id);
        end else begin
          ea = qa.pop_front();
          chk("a_beat_id", a_id, ea.id);
          chk("a_beat_cnt", a_cnt, ea.cnt);
          chk("a_beat_last", a_last, ea.last);
        end
        a_stall = 1'b0;
      end else begin
        a_stall = 1'b1;
        a_sid   = a_id;
        a_scnt  = a_cnt;
      end
    end else if (a_stall) begin
      checks++;
      failures++;
      $display("FAIL a_valid_dropped actual=0 required=1 (stalled beat id %0d)", a_sid);
      a_stall = 1'b0;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (rst && b_valid && b_ready) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_extra_beat actual_id=%0d required=no beat", b_id);
      end else begin
        eb = qb.pop_front();
        chk("b_beat_id", b_id, eb.id);
        chk("b_beat_cnt", b_cnt, eb.cnt);
        chk("b_beat_last", b_last, eb.last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a();
    beat_t t;
    for (int i = 0; i < 8; i++) begin
      t.id = i; t.cnt = exp_a[i]; t.last = (i == 7);
      qa.push_back(t);
    end
  endtask

  task automatic push_b();
    beat_t t;
    for (int i = 0; i < 2; i++) begin
      t.id = i; t.cnt = {28'h0, exp_b[i]}; t.last = (i == 1);
      qb.push_back(t);
    end
  endtask

  task automatic dump_a(input bit toggle, input bit mid_req, input logic [7:0] ev_same);
    bit [3:0] pat;
    int       cyc;
    pat = 4'b1001;
    push_a();
    a_req = 1'b1; a_ev = ev_same; a_ready = 1'b1;
    step();
    a_req = 1'b0; a_ev = '0;
    chk("a_first_valid", a_valid, 1);
    chk("a_first_busy", a_busy, 1);
    chk("a_first_id", a_id, 0);
    cyc = 0;
    while (a_busy && cyc < 100) begin
      a_ready = toggle ? pat[cyc % 4] : 1'b1;
      a_req   = mid_req && (cyc == 3);
      step();
      cyc++;
    end
    a_req = 1'b0; a_ready = 1'b1;
    if (!toggle) chk("a_dump_cycles", cyc, 8);
    chk("a_busy_end", a_busy, 0);
    chk("a_queue_empty", qa.size(), 0);
  endtask

  task automatic dump_b(input logic [1:0] ev_same);
    int cyc;
    push_b();
    b_req = 1'b1; b_ev = ev_same;
    step();
    b_req = 1'b0; b_ev = '0;
    chk("b_first_valid", b_valid, 1);
    cyc = 0;
    while (b_busy && cyc < 50) begin
      step();
      cyc++;
    end
    chk("b_dump_cycles", cyc, 2);
    chk("b_queue_empty", qb.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    a_ev = '0; a_clr = 1'b0; a_req = 1'b0; a_ready = 1'b1;
    b_ev = '0; b_clr = 1'b0; b_req = 1'b0; b_ready = 1'b1;
    #12;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_id", a_id, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_last", a_last, 0);
    chk("rst_b_valid", b_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // event 3 for five cycles
    a_ev = 8'h08;
    repeat (5) step();
    a_ev = '0;
    exp_a = '{32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
    dump_a(1'b0, 1'b0, 8'h00);

    // event 0 in the accept cycle lands only in the live counter
    a_ev = 8'h01;
    repeat (4) step();
    a_ev = '0;
    exp_a = '{32'd4, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
    dump_a(1'b0, 1'b0, 8'h01);
    exp_a = '{32'd5, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
    dump_a(1'b0, 1'b0, 8'h00);

    // clear beats a same-cycle event; then stalled stream with ignored dump_req
    a_ev = 8'h04;
    step();
    a_clr = 1'b1; a_ev = 8'h04;
    step();
    a_clr = 1'b0; a_ev = 8'h02;
    repeat (2) step();
    a_ev = '0;
    exp_a = '{32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    dump_a(1'b1, 1'b1, 8'h00);
    repeat (2) step();
    chk("a_midreq_ignored_busy", a_busy, 0);
    chk("a_midreq_ignored_valid", a_valid, 0);

    // reset in the middle of a dump
    a_ev = 8'h20;
    repeat (3) step();
    a_ev = '0;
    exp_a = '{32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0};
    push_a();
    a_req = 1'b1;
    step();
    a_req = 1'b0;
    repeat (4) step();
    chk("a_pre_rst_id", a_id, 4);
    rst = 1'b0;
    #1;
    chk("a_rst_valid", a_valid, 0);
    chk("a_rst_busy", a_busy, 0);
    chk("a_rst_id", a_id, 0);
    chk("a_rst_cnt", a_cnt, 0);
    chk("a_rst_last", a_last, 0);
    qa.delete();
    step();
    step();
    rst = 1'b1;
    step();
    exp_a = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    dump_a(1'b0, 1'b0, 8'h00);

    // DUT B: wrap through all-ones, then clear-on-dump
    b_ev = 2'b01;
    repeat (17) step();
    b_ev = 2'b10;
    repeat (2) step();
    b_ev = '0;
    exp_b = '{4'd1, 4'd2};
    dump_b(2'b01);
    exp_b = '{4'd0, 4'd0};
    dump_b(2'b00);

    chk("a_queue_final", qa.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
